// File: rtl/dram_arb.sv
// Two-port DRAM access arbiter: CPU (port 0) and DMA (port 1) share one
// controller port; the winner's request is latched and strobed until DSACK.
module dram_arb #(
    parameter int ADDR_W       = 28,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 63
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        REQ,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [1:0]        RNW,
    input  logic [1:0]        SIZ0,
    input  logic [1:0]        SIZ1,
    output logic [1:0]        GNT,
    output logic [1:0]        DONE,
    output logic [1:0]        ERR,
    output logic              DRAM_nAS,
    output logic              DRAM_nRAMSEL,
    output logic              DRAM_RnW,
    output logic [1:0]        DRAM_SIZ,
    output logic [ADDR_W-1:0] DRAM_ADDR,
    input  logic [1:0]        DSACK
);

    localparam int RUN_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STARVE_LIMIT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        RELEASE
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             pick1;
    logic [RUN_W-1:0] run_nxt;

    // CPU keeps winning contested grants until it has taken RUN_MAX in a row
    always_comb begin
        pick1   = 1'b0;
        run_nxt = '0;
        if (REQ == 2'b11) begin
            if (run_cnt < RUN_MAX) begin
                pick1   = 1'b0;
                run_nxt = run_cnt + RUN_W'(1);
            end else begin
                pick1   = 1'b1;
            end
        end else if (REQ == 2'b10) begin
            pick1 = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            run_cnt      <= '0;
            tmo_cnt      <= '0;
            GNT          <= 2'b00;
            DONE         <= 2'b00;
            ERR          <= 2'b00;
            DRAM_nAS     <= 1'b1;
            DRAM_nRAMSEL <= 1'b1;
            DRAM_RnW     <= 1'b1;
            DRAM_SIZ     <= 2'b00;
            DRAM_ADDR    <= '0;
        end else begin
            DONE <= 2'b00;
            ERR  <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (REQ != 2'b00) begin
                        GNT       <= pick1 ? 2'b10 : 2'b01;
                        DRAM_ADDR <= pick1 ? ADDR1 : ADDR0;
                        DRAM_SIZ  <= pick1 ? SIZ1 : SIZ0;
                        DRAM_RnW  <= RNW[pick1];
                        run_cnt   <= run_nxt;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    DRAM_nAS     <= 1'b0;
                    DRAM_nRAMSEL <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (DSACK == 2'b11) begin
                        DONE         <= GNT;
                        DRAM_nAS     <= 1'b1;
                        DRAM_nRAMSEL <= 1'b1;
                        state        <= RELEASE;
                    end else if (tmo_cnt == TMO_MAX) begin
                        ERR          <= GNT;
                        DRAM_nAS     <= 1'b1;
                        DRAM_nRAMSEL <= 1'b1;
                        state        <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (DSACK == 2'b00) begin
                        GNT   <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
